// File: rtl/fnd_codes_pkg.sv
// Display codes understood by the segment driver, plus the scheduler's
// state and display-source encodings.
package fnd_codes_pkg;

  localparam logic [31:0] FND_NULL    = 32'h00CC_0000;
  localparam logic [31:0] FND_ERROR   = 32'h00EE_0000;
  localparam logic [31:0] FND_PLUS    = 32'h0030_0000;
  localparam logic [31:0] FND_MINUS   = 32'h0040_0000;
  localparam logic [31:0] FND_MULT    = 32'h0010_0000;
  localparam logic [31:0] FND_DIV     = 32'h0020_0000;
  localparam logic [31:0] FND_MOD     = 32'h0050_0000;
  localparam logic [31:0] FND_HAPPY   = 32'h00A0_0000;
  localparam logic [31:0] FND_ANS     = 32'h00B0_0000;
  localparam logic [31:0] FND_NEG_ANS = 32'hE0B0_0000;

  typedef enum logic [1:0] {
    ST_VAL = 2'd0,
    ST_MSG = 2'd1,
    ST_ERR = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    SRC_VAL   = 2'd0,
    SRC_MSG   = 2'd1,
    SRC_ERR   = 2'd2,
    SRC_BLANK = 2'd3
  } src_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clocks, restartable
// through a synchronous clear.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_reg;

  // tick must not depend on clr: the scheduler derives clr from tick.
  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + PW'(1);
    end
  end

endmodule

// File: rtl/fnd_display_scheduler.sv
// Chooses the word driven to the 6-digit segment driver: held value, timed
// messages with a one-deep queue, blinking ERROR, or forced blank.
module fnd_display_scheduler
  import fnd_codes_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int MSG_MS   = 1000,
  parameter int BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        val_valid,
  input  logic [31:0] val_data,
  input  logic        msg_valid,
  input  logic [31:0] msg_code,
  output logic        msg_ready,
  input  logic        err_set,
  input  logic        err_clr,
  input  logic        blank,
  output logic [31:0] fnd_serial,
  output logic [1:0]  src,
  output logic        busy
);

  localparam int MW = $clog2(max_int(MSG_MS, BLINK_MS) + 1);

  sched_state_t  state_reg, state_next;
  logic [31:0]   value_reg, value_next;
  logic [31:0]   active_reg, active_next;
  logic [31:0]   pend_reg, pend_next;
  logic          pend_full_reg, pend_full_next;
  logic          phase_reg, phase_next;
  logic [MW-1:0] ms_cnt_reg, ms_cnt_next;
  logic [31:0]   serial_reg, serial_next;
  src_t          src_reg, src_next;
  logic          busy_reg, busy_next;
  logic          ready_reg, ready_next;

  logic tick;
  logic timer_clr;
  logic msg_accept;
  logic msg_done;
  logic blink_done;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  assign msg_accept = msg_valid && ready_reg;
  assign msg_done   = tick && (ms_cnt_reg == MW'(MSG_MS - 1));
  assign blink_done = tick && (ms_cnt_reg == MW'(BLINK_MS - 1));

  always_comb begin
    state_next     = state_reg;
    active_next    = active_reg;
    pend_next      = pend_reg;
    pend_full_next = pend_full_reg;
    phase_next     = phase_reg;
    timer_clr      = 1'b0;
    ms_cnt_next    = tick ? ms_cnt_reg + MW'(1) : ms_cnt_reg;
    value_next     = val_valid ? val_data : value_reg;

    if (err_set) begin
      state_next     = ST_ERR;
      pend_full_next = 1'b0;
      phase_next     = 1'b0;
      timer_clr      = 1'b1;
    end else begin
      case (state_reg)
        ST_VAL: begin
          if (msg_accept) begin
            state_next  = ST_MSG;
            active_next = msg_code;
            timer_clr   = 1'b1;
          end
        end
        ST_MSG: begin
          if (msg_done) begin
            if (pend_full_reg) begin
              active_next    = pend_reg;
              pend_full_next = 1'b0;
              timer_clr      = 1'b1;
            end else if (msg_accept) begin
              active_next = msg_code;
              timer_clr   = 1'b1;
            end else begin
              state_next = ST_VAL;
            end
          end else if (msg_accept) begin
            pend_next      = msg_code;
            pend_full_next = 1'b1;
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state_next = ST_VAL;
          end else if (blink_done) begin
            phase_next  = ~phase_reg;
            ms_cnt_next = '0;
          end
        end
        default: state_next = ST_VAL;
      endcase
    end

    if (timer_clr) begin
      ms_cnt_next = '0;
    end

    // Outputs are computed from next-state values so they register alongside it.
    case (state_next)
      ST_MSG: begin
        serial_next = active_next;
        src_next    = SRC_MSG;
      end
      ST_ERR: begin
        serial_next = phase_next ? FND_NULL : FND_ERROR;
        src_next    = SRC_ERR;
      end
      default: begin
        serial_next = value_next;
        src_next    = SRC_VAL;
      end
    endcase
    if (blank) begin
      serial_next = FND_NULL;
      src_next    = SRC_BLANK;
    end
    busy_next  = (state_next == ST_MSG);
    ready_next = (state_next != ST_ERR) && !pend_full_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_VAL;
      value_reg     <= '0;
      active_reg    <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      phase_reg     <= 1'b0;
      ms_cnt_reg    <= '0;
      serial_reg    <= FND_NULL;
      src_reg       <= SRC_VAL;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      value_reg     <= value_next;
      active_reg    <= active_next;
      pend_reg      <= pend_next;
      pend_full_reg <= pend_full_next;
      phase_reg     <= phase_next;
      ms_cnt_reg    <= ms_cnt_next;
      serial_reg    <= serial_next;
      src_reg       <= src_next;
      busy_reg      <= busy_next;
      ready_reg     <= ready_next;
    end
  end

  assign fnd_serial = serial_reg;
  assign src        = src_reg;
  assign busy       = busy_reg;
  assign msg_ready  = ready_reg;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed bench for fnd_display_scheduler with short timing parameters
// (TICK_DIV=4, MSG_MS=3, BLINK_MS=2: messages 12 cycles, blink phases 8).
module tb_fnd_display_scheduler;
  import fnd_codes_pkg::*;

  localparam logic [31:0] VAL_1234 = 32'h0000_04D2;
  localparam int          BOUND    = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        val_valid;
  logic [31:0] val_data;
  logic        msg_valid;
  logic [31:0] msg_code;
  logic        msg_ready;
  logic        err_set;
  logic        err_clr;
  logic        blank;
  logic [31:0] fnd_serial;
  logic [1:0]  src;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  fnd_display_scheduler #(.TICK_DIV(4), .MSG_MS(3), .BLINK_MS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .val_valid  (val_valid),
    .val_data   (val_data),
    .msg_valid  (msg_valid),
    .msg_code   (msg_code),
    .msg_ready  (msg_ready),
    .err_set    (err_set),
    .err_clr    (err_clr),
    .blank      (blank),
    .fnd_serial (fnd_serial),
    .src        (src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-18s got=%h", tag, got);
    end else begin
      $display("FAIL %-18s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ready_seen;

    rst = 1'b0; val_valid = 1'b0; val_data = '0; msg_valid = 1'b0; msg_code = '0;
    err_set = 1'b0; err_clr = 1'b0; blank = 1'b0;

    // 1. reset state, release, value load
    repeat (3) step();
    check("rst_serial", fnd_serial, FND_NULL);
    check("rst_src", 32'(src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(msg_ready), 32'd0);
    rst = 1'b1;
    step();
    check("rel_ready", 32'(msg_ready), 32'd1);
    check("rel_serial", fnd_serial, 32'd0);
    val_valid = 1'b1; val_data = VAL_1234;
    step();
    val_valid = 1'b0;
    check("val_serial", fnd_serial, VAL_1234);
    check("val_src", 32'(src), 32'd0);

    // 2. single message lasts 12 cycles
    msg_valid = 1'b1; msg_code = FND_PLUS;
    step();
    msg_valid = 1'b0;
    check("plus_serial", fnd_serial, FND_PLUS);
    check("plus_src", 32'(src), 32'd1);
    n = 0;
    while (busy && n < BOUND) begin n++; step(); end
    check("plus_len", 32'(n), 32'd12);
    check("plus_after", fnd_serial, VAL_1234);
    check("plus_after_src", 32'(src), 32'd0);

    // 3. queued message plus a stalled third request
    msg_valid = 1'b1; msg_code = FND_PLUS;
    step();
    msg_valid = 1'b0;
    step();
    msg_valid = 1'b1; msg_code = FND_MINUS;
    step();
    check("q_ready_low", 32'(msg_ready), 32'd0);
    check("q_serial_plus", fnd_serial, FND_PLUS);
    msg_code = FND_HAPPY;
    n = 2; ready_seen = 0;
    while (fnd_serial == FND_PLUS && n < BOUND) begin
      if (msg_ready) ready_seen++;
      n++; step();
    end
    check("q_plus_len", 32'(n), 32'd12);
    check("q_stall_ready", 32'(ready_seen), 32'd0);
    check("q_minus_serial", fnd_serial, FND_MINUS);
    check("q_minus_ready", 32'(msg_ready), 32'd1);
    step();
    msg_valid = 1'b0;
    check("q_happy_pend", 32'(msg_ready), 32'd0);
    n = 1;
    while (fnd_serial == FND_MINUS && n < BOUND) begin n++; step(); end
    check("q_minus_len", 32'(n), 32'd12);
    check("q_happy_serial", fnd_serial, FND_HAPPY);

    // 4. error with pending full, blink, clear
    msg_valid = 1'b1; msg_code = FND_MULT;
    step();
    msg_valid = 1'b0;
    check("e_pend_full", 32'(msg_ready), 32'd0);
    err_set = 1'b1;
    step();
    err_set = 1'b0;
    check("e_serial", fnd_serial, FND_ERROR);
    check("e_src", 32'(src), 32'd2);
    check("e_busy", 32'(busy), 32'd0);
    check("e_ready", 32'(msg_ready), 32'd0);
    n = 0;
    while (fnd_serial == FND_ERROR && n < BOUND) begin n++; step(); end
    check("e_err_phase", 32'(n), 32'd8);
    check("e_null_serial", fnd_serial, FND_NULL);
    n = 0;
    while (fnd_serial == FND_NULL && n < BOUND) begin n++; step(); end
    check("e_null_phase", 32'(n), 32'd8);
    check("e_err_again", fnd_serial, FND_ERROR);
    err_set = 1'b1; err_clr = 1'b1;
    step();
    err_set = 1'b0; err_clr = 1'b0;
    check("e_both_src", 32'(src), 32'd2);
    check("e_both_serial", fnd_serial, FND_ERROR);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("e_clr_serial", fnd_serial, VAL_1234);
    check("e_clr_src", 32'(src), 32'd0);
    check("e_clr_ready", 32'(msg_ready), 32'd1);
    step();
    check("e_no_pend_msg", fnd_serial, VAL_1234);

    // 5. blank during a message
    msg_valid = 1'b1; msg_code = FND_PLUS;
    step();
    msg_valid = 1'b0;
    check("b_plus", fnd_serial, FND_PLUS);
    blank = 1'b1;
    step();
    check("b_serial", fnd_serial, FND_NULL);
    check("b_src", 32'(src), 32'd3);
    check("b_busy", 32'(busy), 32'd1);
    repeat (15) step();
    check("b_expired", 32'(busy), 32'd0);
    check("b_still_null", fnd_serial, FND_NULL);
    blank = 1'b0;
    step();
    check("b_off_serial", fnd_serial, VAL_1234);
    check("b_off_src", 32'(src), 32'd0);

    // 6. reset mid-message with pending full
    msg_valid = 1'b1; msg_code = FND_PLUS;
    step();
    msg_code = FND_MINUS;
    step();
    msg_valid = 1'b0;
    check("r_pend_full", 32'(msg_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("r_async_serial", fnd_serial, FND_NULL);
    check("r_async_busy", 32'(busy), 32'd0);
    check("r_async_ready", 32'(msg_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("r_rel_ready", 32'(msg_ready), 32'd1);
    check("r_rel_serial", fnd_serial, 32'd0);
    msg_valid = 1'b1; msg_code = FND_ANS;
    step();
    msg_valid = 1'b0;
    check("r_ans_serial", fnd_serial, FND_ANS);
    n = 0;
    while (busy && n < BOUND) begin n++; step(); end
    check("r_ans_len", 32'(n), 32'd12);
    check("r_no_pend", fnd_serial, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
